ids_channel_scheduler: RTL and testbench

- Sequences the IDS channel model: accepts one N-bit strand per handshake, and runs the channel model TIMES times on that strand.
- Emits each noisy read with its length, copy index and status on a valid/ready output stream.
- Owns the channel model's load/reset pin and detects runs that never complete.
- Sits between the strand source and the read-collection/decoder path.

---
 rtl/ids_channel_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_ids_channel_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ids_channel_scheduler.sv
// ids_channel_scheduler
//   Feeds one strand at a time into the IDS channel model and replays it
//   TIMES times, emitting each noisy read on a valid/ready stream. Owns the
//   model's active-low load/reset pin and truncates copies that never finish.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_valid/s_ready/s_data   strand input stream (accepted only in IDLE)
//   gen_rst_n, gen_data      load/reset and strand to the channel model
//   gen_ready, gen_len,
//   gen_data_out             done pulse, read length and noisy read from model
//   m_valid/m_ready, m_data,
//   m_len, m_copy, m_last,
//   m_trunc                  noisy read output stream
//   busy                     not IDLE
//   trunc_cnt                saturating count of truncated copies
module ids_channel_scheduler #(
    parameter int N          = 10,
    parameter int DATA_WIDTH = 32,
    parameter int TIMES      = 4,
    parameter int TIMEOUT    = 256,
    parameter int LEN_W      = $clog2(DATA_WIDTH + 1),
    parameter int COPY_W     = $clog2(TIMES) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [N-1:0]          s_data,
    output logic                  gen_rst_n,
    output logic [N-1:0]          gen_data,
    input  logic                  gen_ready,
    input  logic [31:0]           gen_len,
    input  logic [DATA_WIDTH-1:0] gen_data_out,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [LEN_W-1:0]      m_len,
    output logic [COPY_W-1:0]     m_copy,
    output logic                  m_last,
    output logic                  m_trunc,
    output logic                  busy,
    output logic [15:0]           trunc_cnt
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

    state_t                state_q, state_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [COPY_W-1:0]     copy_q, copy_d;
    logic [N-1:0]          gen_data_q, gen_data_d;
    logic                  gen_rst_n_q, gen_rst_n_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [LEN_W-1:0]      m_len_q, m_len_d;
    logic                  m_last_q, m_last_d;
    logic                  m_trunc_q, m_trunc_d;
    logic [15:0]           trunc_cnt_q, trunc_cnt_d;

    logic                  copy_is_last;
    logic                  timed_out;
    logic [LEN_W-1:0]      len_clamped;

    assign copy_is_last = (copy_q == COPY_W'(TIMES - 1));
    assign timed_out    = (timer_q == TMR_W'(TIMEOUT - 1));

    // gen_len is a signed int: negative lengths read as empty, long ones
    // are capped at the buffer width.
    always_comb begin
        len_clamped = gen_len[LEN_W-1:0];
        if (gen_len[31])
            len_clamped = '0;
        else if (gen_len > 32'(DATA_WIDTH))
            len_clamped = LEN_W'(DATA_WIDTH);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state; gen_ready wins over a same-cycle timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (s_valid) state_d = LOAD;
            LOAD: state_d = RUN;
            RUN:  if (gen_ready || timed_out) state_d = HOLD;
            HOLD: if (m_ready) state_d = copy_is_last ? IDLE : LOAD;
            default: state_d = IDLE;
        endcase
    end

    // Outputs / datapath
    always_comb begin
        timer_d     = timer_q;
        copy_d      = copy_q;
        gen_data_d  = gen_data_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_len_d     = m_len_q;
        m_last_d    = m_last_q;
        m_trunc_d   = m_trunc_q;
        trunc_cnt_d = trunc_cnt_q;
        // Registered so the model is released exactly while the FSM is in RUN.
        gen_rst_n_d = (state_d == RUN);
        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    gen_data_d = s_data;
                    copy_d     = '0;
                end
            end
            LOAD: timer_d = '0;
            RUN: begin
                timer_d = timer_q + 1'b1;
                if (gen_ready) begin
                    m_valid_d = 1'b1;
                    m_data_d  = gen_data_out;
                    m_len_d   = len_clamped;
                    m_trunc_d = 1'b0;
                    m_last_d  = copy_is_last;
                end else if (timed_out) begin
                    m_valid_d = 1'b1;
                    m_data_d  = '0;
                    m_len_d   = '0;
                    m_trunc_d = 1'b1;
                    m_last_d  = copy_is_last;
                    if (trunc_cnt_q != 16'hFFFF)
                        trunc_cnt_d = trunc_cnt_q + 16'd1;
                end
            end
            HOLD: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    if (!copy_is_last) copy_d = copy_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q     <= '0;
            copy_q      <= '0;
            gen_data_q  <= '0;
            gen_rst_n_q <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_len_q     <= '0;
            m_last_q    <= 1'b0;
            m_trunc_q   <= 1'b0;
            trunc_cnt_q <= '0;
        end else begin
            timer_q     <= timer_d;
            copy_q      <= copy_d;
            gen_data_q  <= gen_data_d;
            gen_rst_n_q <= gen_rst_n_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_len_q     <= m_len_d;
            m_last_q    <= m_last_d;
            m_trunc_q   <= m_trunc_d;
            trunc_cnt_q <= trunc_cnt_d;
        end
    end

    assign s_ready   = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign gen_rst_n = gen_rst_n_q;
    assign gen_data  = gen_data_q;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_len     = m_len_q;
    assign m_copy    = copy_q;
    assign m_last    = m_last_q;
    assign m_trunc   = m_trunc_q;
    assign trunc_cnt = trunc_cnt_q;

endmodule

// File: tb/tb_ids_channel_scheduler.sv
// Bench for ids_channel_scheduler: a stub channel model (fixed delay, or echo
// of the loaded strand as an error-free model would produce), a table of
// directed strands, a reset-mid-run sequence and randomized strands checked
// against expectations derived from the read rules.
module tb_ids_channel_scheduler;

    localparam int N = 10, DW = 32, TIMES = 4, TIMEOUT = 256;
    localparam int LEN_W = $clog2(DW + 1), COPY_W = $clog2(TIMES) + 1;
    localparam int NEVER = 100000;

    logic              clk = 1'b0, rst = 1'b1;
    logic              s_valid = 1'b0, s_ready;
    logic [N-1:0]      s_data = '0;
    logic              gen_rst_n, gen_ready;
    logic [N-1:0]      gen_data;
    logic [31:0]       gen_len;
    logic [DW-1:0]     gen_data_out;
    logic              m_valid, m_ready = 1'b0;
    logic [DW-1:0]     m_data;
    logic [LEN_W-1:0]  m_len;
    logic [COPY_W-1:0] m_copy;
    logic              m_last, m_trunc, busy;
    logic [15:0]       trunc_cnt;

    ids_channel_scheduler #(.N(N), .DATA_WIDTH(DW), .TIMES(TIMES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .gen_rst_n(gen_rst_n), .gen_data(gen_data), .gen_ready(gen_ready),
        .gen_len(gen_len), .gen_data_out(gen_data_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_len(m_len),
        .m_copy(m_copy), .m_last(m_last), .m_trunc(m_trunc),
        .busy(busy), .trunc_cnt(trunc_cnt)
    );

    always #5 clk = ~clk;

    // Stub channel model
    int            stub_delay = NEVER;
    int            stub_len   = 0;
    logic [DW-1:0] stub_data  = '0;
    bit            stub_echo  = 1'b0;
    bit            stub_force = 1'b0;
    int            run_cnt    = 0;
    logic [N-1:0]  loaded     = '0;

    always @(posedge clk) begin
        if (!gen_rst_n) begin
            run_cnt <= 0;
            loaded  <= gen_data;
        end else begin
            run_cnt <= run_cnt + 1;
        end
    end

    assign gen_ready    = stub_force | (gen_rst_n && (run_cnt == stub_delay - 1));
    assign gen_len      = stub_echo ? 32'(N) : stub_len;
    assign gen_data_out = stub_echo ? DW'(loaded) : stub_data;

    typedef struct {
        logic [N-1:0]     strand;
        int               delay;
        int               len;
        logic [DW-1:0]    data;
        bit               echo;
        int               bp;
        logic [LEN_W-1:0] e_len;
        logic [DW-1:0]    e_data;
        bit               e_trunc;
        int               e_run;
    } vec_t;

    int n_chk = 0, n_fail = 0, exp_tc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [N-1:0] s, input int d, input int l,
                                input logic [DW-1:0] dat, input bit e, input int bp,
                                input logic [LEN_W-1:0] el, input logic [DW-1:0] ed,
                                input bit et, input int er);
        vec_t v;
        v.strand = s; v.delay = d; v.len = l; v.data = dat; v.echo = e; v.bp = bp;
        v.e_len = el; v.e_data = ed; v.e_trunc = et; v.e_run = er;
        return v;
    endfunction

    // Reference: what a read must look like given the stub's behaviour.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int   l = v.echo ? N : v.len;
        r.e_trunc = (v.delay > TIMEOUT);
        r.e_run   = r.e_trunc ? TIMEOUT : v.delay;
        if (l < 0)  l = 0;
        if (l > DW) l = DW;
        r.e_len  = r.e_trunc ? '0 : LEN_W'(l);
        r.e_data = r.e_trunc ? '0 : (v.echo ? DW'(v.strand) : v.data);
        return r;
    endfunction

    task automatic set_stub(input vec_t v);
        stub_delay = v.delay; stub_len = v.len; stub_data = v.data; stub_echo = v.echo;
    endtask

    task automatic accept(input vec_t v);
        int cyc = 0;
        while (!s_ready && cyc < 100) begin @(negedge clk); cyc++; end
        chk("s_ready_wait", s_ready, 1);
        s_valid = 1'b1; s_data = v.strand;
        @(negedge clk);
        s_valid = 1'b0; s_data = ~v.strand;
    endtask

    // Wait for one read, check it, optionally stall it, then hand it off.
    task automatic get_read(input int c, input vec_t v, output bit ok);
        int run = 0, ld = 0, cyc = 0;
        logic [63:0] snap;
        bit stable;
        while (!m_valid && cyc < 700) begin
            if (gen_rst_n) run++;
            else if (busy) ld++;
            @(negedge clk); cyc++;
        end
        ok = m_valid;
        chk($sformatf("read_wait c%0d", c), m_valid, 1);
        if (!ok) return;
        chk($sformatf("copy c%0d", c), m_copy, c);
        chk($sformatf("last c%0d", c), m_last, (c == TIMES - 1));
        chk($sformatf("len c%0d", c), m_len, v.e_len);
        chk($sformatf("data c%0d", c), m_data, v.e_data);
        chk($sformatf("trunc c%0d", c), m_trunc, v.e_trunc);
        chk($sformatf("run_cycles c%0d", c), run, v.e_run);
        chk($sformatf("load_cycles c%0d", c), ld, 1);
        chk($sformatf("gen_data c%0d", c), gen_data, v.strand);
        if (v.bp > 0) begin
            snap = 64'({m_data, m_len, m_copy, m_last, m_trunc});
            stable = 1'b1;
            s_valid = 1'b1; s_data = ~v.strand; stub_force = 1'b1;
            repeat (v.bp) begin
                @(negedge clk);
                if (64'({m_data, m_len, m_copy, m_last, m_trunc}) !== snap ||
                    !m_valid || gen_rst_n || s_ready) stable = 1'b0;
            end
            s_valid = 1'b0; stub_force = 1'b0;
            chk($sformatf("bp_stable c%0d", c), stable, 1);
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic run_strand(input vec_t v);
        bit ok = 1'b0;
        set_stub(v);
        accept(v);
        for (int c = 0; c < TIMES; c++) begin
            get_read(c, v, ok);
            if (!ok) break;
        end
        chk("s_ready_after", s_ready, 1);
        chk("busy_after", busy, 0);
        if (v.e_trunc) exp_tc += TIMES;
        chk("trunc_cnt", trunc_cnt, exp_tc);
    endtask

    vec_t tbl[8];

    initial begin
        vec_t v;
        bit ok;
        int cyc;
        bit seen;

        tbl[0] = mk(10'h2B5, 12,   10, 32'h3A5,      0, 0,  10, 32'h3A5,      0, 12);
        tbl[1] = mk(10'h2B5, 12,   10, 32'h3A5,      0, 20, 10, 32'h3A5,      0, 12);
        tbl[2] = mk(10'h3FF, NEVER, 10, 32'h3A5,     0, 0,  0,  32'h0,        1, 256);
        tbl[3] = mk(10'h011, 5,    40, 32'hDEADBEEF, 0, 0,  32, 32'hDEADBEEF, 0, 5);
        tbl[4] = mk(10'h022, 5,    -1, 32'h1234,     0, 3,  0,  32'h1234,     0, 5);
        tbl[5] = mk(10'h155, 7,    0,  32'h0,        1, 0,  10, 32'h155,      0, 7);
        tbl[6] = mk(10'h0AA, 256,  3,  32'h77,       0, 0,  3,  32'h77,       0, 256);
        tbl[7] = mk(10'h0CC, 257,  3,  32'h77,       0, 2,  0,  32'h0,        1, 256);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst gen_rst_n", gen_rst_n, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst m_valid", m_valid, 0);
        chk("rst m_data", m_data, 0);
        chk("rst m_len", m_len, 0);
        chk("rst m_copy", m_copy, 0);
        chk("rst m_last", m_last, 0);
        chk("rst m_trunc", m_trunc, 0);
        chk("rst trunc_cnt", trunc_cnt, 0);
        chk("rst gen_data", gen_data, 0);
        chk("rst busy", busy, 0);
        chk("rst s_ready", s_ready, 1);

        foreach (tbl[i]) run_strand(tbl[i]);

        // Reset during RUN of copy 2
        v = mk(10'h0F0, 12, 10, 32'h3A5, 0, 0, 10, 32'h3A5, 0, 12);
        set_stub(v);
        accept(v);
        get_read(0, v, ok);
        get_read(1, v, ok);
        cyc = 0;
        while (!gen_rst_n && cyc < 20) begin @(negedge clk); cyc++; end
        chk("mid_run reached", gen_rst_n, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_tc = 0;
        chk("midrst m_valid", m_valid, 0);
        chk("midrst m_copy", m_copy, 0);
        chk("midrst trunc_cnt", trunc_cnt, 0);
        chk("midrst s_ready", s_ready, 1);
        chk("midrst busy", busy, 0);
        chk("midrst gen_rst_n", gen_rst_n, 0);
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (m_valid || busy) seen = 1'b1; end
        chk("midrst no_read", seen, 0);

        // Randomized strands
        for (int k = 0; k < 16; k++) begin
            v.strand = N'($urandom);
            v.delay  = ($urandom_range(0, 7) == 0) ? 300 : int'($urandom_range(1, 40));
            v.len    = int'($urandom_range(0, 50)) - 5;
            v.data   = $urandom;
            v.echo   = ($urandom_range(0, 3) == 0);
            v.bp     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
            run_strand(model(v));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
